// File: rtl/pipelined_comparator.sv
// pipelined_comparator: two-stage comparator for branch conditions and,
// optionally, min/max selection.
// Optional feature macro: PIPELINED_COMPARATOR_MINMAX_EN enables the min/max
// datapath and the stage-1 operand registers it needs. Without it, in_minmax
// requests are flagged illegal and out_data stays 0.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Once out_valid is high, out_* hold until out_ready takes them.
// Stage 1 captures per-segment lt/eq vectors; stage 2 is the output register.
module pipelined_comparator #(
  parameter int WIDTH     = 32,
  parameter int SEGMENTS  = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data1,
  input  logic [WIDTH-1:0]     in_data2,
  input  logic [2:0]           in_func3,
  input  logic                 in_minmax,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_result,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal
);

  // Bits below the MSB are split into equal segments; the top one is zero-padded.
  localparam int LOW_W = WIDTH - 1;
  localparam int SEG_W = (LOW_W + SEGMENTS - 1) / SEGMENTS;
  localparam int PAD_W = SEG_W * SEGMENTS;

  logic [PAD_W-1:0]    a_low;
  logic [PAD_W-1:0]    b_low;
  logic [SEGMENTS-1:0] seg_lt;
  logic [SEGMENTS-1:0] seg_eq;

  // Stage 1 state
  logic                 s1_valid;
  logic [SEGMENTS-1:0]  s1_lt;
  logic [SEGMENTS-1:0]  s1_eq;
  logic                 s1_a_msb;
  logic                 s1_b_msb;
  logic [2:0]           s1_func3;
  logic                 s1_minmax;
  logic [TAG_WIDTH-1:0] s1_tag;
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [WIDTH-1:0]     s2_data;
  logic [WIDTH-1:0]     nxt_data;
`endif

  // Flow control
  logic s2_ready;
  logic s1_ready;

  // Stage 2 combine
  logic low_lt;
  logic low_found;
  logic low_eq;
  logic msb_eq;
  logic lt_s;
  logic lt_u;
  logic eq_all;
  logic nxt_result;
  logic nxt_illegal;

  assign a_low = PAD_W'(in_data1[WIDTH-2:0]);
  assign b_low = PAD_W'(in_data2[WIDTH-2:0]);

  // Per-segment unsigned sub-comparators on the low bits.
  always_comb begin
    seg_lt = '0;
    seg_eq = '0;
    for (int i = 0; i < SEGMENTS; i++) begin
      seg_lt[i] = a_low[i*SEG_W +: SEG_W] < b_low[i*SEG_W +: SEG_W];
      seg_eq[i] = a_low[i*SEG_W +: SEG_W] == b_low[i*SEG_W +: SEG_W];
    end
  end

  // A stage moves forward when the stage after it is empty or emptying.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = !rst && !flush && s1_ready;

  // Stage 1 valid bit: reset and flush drop whatever is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 payload, captured only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_lt     <= seg_lt;
      s1_eq     <= seg_eq;
      s1_a_msb  <= in_data1[WIDTH-1];
      s1_b_msb  <= in_data2[WIDTH-1];
      s1_func3  <= in_func3;
      s1_minmax <= in_minmax;
      s1_tag    <= in_tag;
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
      s1_a      <= in_data1;
      s1_b      <= in_data2;
`endif
    end
  end

  // Low-bit lt comes from the most significant segment that differs.
  always_comb begin
    low_lt    = 1'b0;
    low_found = 1'b0;
    for (int i = SEGMENTS - 1; i >= 0; i--) begin
      if (!low_found && !s1_eq[i]) begin
        low_lt    = s1_lt[i];
        low_found = 1'b1;
      end
    end
  end

  assign low_eq = &s1_eq;
  assign msb_eq = (s1_a_msb == s1_b_msb);
  assign lt_s   = (s1_a_msb && !s1_b_msb) || (msb_eq && low_lt);
  assign lt_u   = (!s1_a_msb && s1_b_msb) || (msb_eq && low_lt);
  assign eq_all = msb_eq && low_eq;

  // Condition / min-max decode feeding the output register.
  always_comb begin
    nxt_result  = 1'b0;
    nxt_illegal = 1'b0;
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
    nxt_data    = '0;
`endif
    if (!s1_minmax) begin
      case (s1_func3)
        3'b000:  nxt_result = eq_all;
        3'b001:  nxt_result = !eq_all;
        3'b100:  nxt_result = lt_s;
        3'b101:  nxt_result = !lt_s;
        3'b110:  nxt_result = lt_u;
        3'b111:  nxt_result = !lt_u;
        default: nxt_illegal = 1'b1;
      endcase
    end else begin
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
      // Ties select operand 1.
      case (s1_func3)
        3'b100:  nxt_data = (lt_s || eq_all) ? s1_a : s1_b;
        3'b101:  nxt_data = (lt_u || eq_all) ? s1_a : s1_b;
        3'b110:  nxt_data = lt_s ? s1_b : s1_a;
        3'b111:  nxt_data = lt_u ? s1_b : s1_a;
        default: nxt_illegal = 1'b1;
      endcase
`else
      nxt_illegal = 1'b1;
`endif
    end
  end

  // Stage 2 output register: holds while stalled, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= 1'b0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
      s2_data     <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= nxt_result;
        out_tag     <= s1_tag;
        out_illegal <= nxt_illegal;
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
        s2_data     <= nxt_data;
`endif
      end
    end
  end

`ifdef PIPELINED_COMPARATOR_MINMAX_EN
  assign out_data = s2_data;
`else
  assign out_data = '0;
`endif

endmodule

// File: tb/tb_pipelined_comparator.sv
// Bench for pipelined_comparator: a default-parameter instance for the
// directed vectors and sequences, plus a WIDTH=13/SEGMENTS=5 instance for
// randomized traffic. Both are scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_comparator;
  localparam int W   = 32;
  localparam int W2  = 13;
  localparam int TW  = 5;
  localparam int EW  = W + 2 + TW;
  localparam int EW2 = W2 + 2 + TW;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic          in_valid, in_ready, in_minmax, out_valid, out_ready, out_result, out_illegal;
  logic [W-1:0]  in_data1, in_data2, out_data;
  logic [2:0]    in_func3;
  logic [TW-1:0] in_tag, out_tag;

  logic          b_in_valid, b_in_ready, b_in_minmax, b_out_valid, b_out_ready, b_out_result, b_out_illegal;
  logic [W2-1:0] b_in_data1, b_in_data2, b_out_data;
  logic [2:0]    b_in_func3;
  logic [TW-1:0] b_in_tag, b_out_tag;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [EW-1:0]  exp_q[$];
  logic [EW2-1:0] exp2_q[$];

  logic smp_in_ready, smp_b_in_ready, acc, b_acc;
  logic stall, b_stall;
  logic [EW:0]  held;
  logic [EW2:0] b_held;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    f;
    logic          mm;
    logic [TW-1:0] tag;
    logic          res;
    logic          ill;
    logic [W-1:0]  dat;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] bnd[4];

  always #5 clk = ~clk;

  pipelined_comparator #(.WIDTH(W), .SEGMENTS(4), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .in_func3(in_func3), .in_minmax(in_minmax), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  pipelined_comparator #(.WIDTH(W2), .SEGMENTS(5), .TAG_WIDTH(TW)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data1(b_in_data1), .in_data2(b_in_data2),
    .in_func3(b_in_func3), .in_minmax(b_in_minmax), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_data(b_out_data),
    .out_tag(b_out_tag), .out_illegal(b_out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain signed/unsigned arithmetic on w-bit operands.
  // Returns {illegal, result, data[63:0]}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] f, input logic mm, input int w);
    logic [63:0] mask, ua, ub, dat;
    longint sa, sb;
    logic ill, res;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = longint'($signed(ua << (64 - w)) >>> (64 - w));
    sb = longint'($signed(ub << (64 - w)) >>> (64 - w));
    ill = 1'b0;
    res = 1'b0;
    dat = '0;
    if (!mm) begin
      case (f)
        3'd0: res = (ua == ub);
        3'd1: res = (ua != ub);
        3'd4: res = (sa < sb);
        3'd5: res = (sa >= sb);
        3'd6: res = (ua < ub);
        3'd7: res = (ua >= ub);
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
      case (f)
        3'd4: dat = (sb < sa) ? ub : ua;
        3'd5: dat = (ub < ua) ? ub : ua;
        3'd6: dat = (sb > sa) ? ub : ua;
        3'd7: dat = (ub > ua) ? ub : ua;
        default: ill = 1'b1;
      endcase
`else
      ill = 1'b1;
`endif
    end
    return {ill, res, dat};
  endfunction

  // One clock: sample and score at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [65:0] m;
    @(negedge clk);
    smp_in_ready   = in_ready;
    smp_b_in_ready = b_in_ready;
    acc   = in_valid && in_ready;
    b_acc = b_in_valid && b_in_ready;
    if (rst || flush) begin
      exp_q.delete();
      exp2_q.delete();
      stall   = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (stall)
        chk("stall_hold_a", {out_valid, out_result, out_illegal, out_data, out_tag}, held);
      if (b_stall)
        chk("stall_hold_b", {b_out_valid, b_out_result, b_out_illegal, b_out_data, b_out_tag}, b_held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL out_extra_a: got tag %0h, required no output (cycle %0d)", out_tag, cyc);
        end else begin
          chk("out_a", {out_illegal, out_result, out_data, out_tag}, exp_q.pop_front());
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (exp2_q.size() == 0) begin
          checks++;
          $display("FAIL out_extra_b: got tag %0h, required no output (cycle %0d)", b_out_tag, cyc);
        end else begin
          chk("out_b", {b_out_illegal, b_out_result, b_out_data, b_out_tag}, exp2_q.pop_front());
        end
      end
      if (acc) begin
        m = model(64'(in_data1), 64'(in_data2), in_func3, in_minmax, W);
        exp_q.push_back({m[65], m[64], m[W-1:0], in_tag});
      end
      if (b_acc) begin
        m = model(64'(b_in_data1), 64'(b_in_data2), b_in_func3, b_in_minmax, W2);
        exp2_q.push_back({m[65], m[64], m[W2-1:0], b_in_tag});
      end
      stall   = out_valid && !out_ready;
      held    = {out_valid, out_result, out_illegal, out_data, out_tag};
      b_stall = b_out_valid && !b_out_ready;
      b_held  = {b_out_valid, b_out_result, b_out_illegal, b_out_data, b_out_tag};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic new_a(input logic [TW-1:0] tg);
    int k;
    k = int'($urandom_range(0, 7));
    in_data1 = $urandom;
    in_data2 = $urandom;
    if (k == 0) in_data2 = in_data1;
    if (k == 1) in_data1 = bnd[$urandom_range(0, 3)];
    if (k == 2) in_data2 = bnd[$urandom_range(0, 3)];
    in_func3  = 3'($urandom_range(0, 7));
    in_minmax = ($urandom_range(0, 3) == 0);
    in_tag    = tg;
  endtask

  task automatic new_b(input logic [TW-1:0] tg);
    b_in_data1 = W2'($urandom_range(0, 8191));
    b_in_data2 = ($urandom_range(0, 5) == 0) ? b_in_data1 : W2'($urandom_range(0, 8191));
    b_in_func3  = 3'($urandom_range(0, 7));
    b_in_minmax = ($urandom_range(0, 3) == 0);
    b_in_tag    = tg;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() + exp2_q.size()) > 0; k++) tick();
    tick();
    tick();
    chk("drain_a", 64'(exp_q.size()), 0);
    chk("drain_b", 64'(exp2_q.size()), 0);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                              input logic mm, input logic [TW-1:0] tg, input logic res,
                              input logic ill, input logic [W-1:0] dat);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.mm = mm; v.tag = tg;
    v.res = res; v.ill = ill; v.dat = dat;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] tg;
    logic [TW-1:0] tg_b;
    bnd[0] = 32'h0000_0000;
    bnd[1] = 32'h7FFF_FFFF;
    bnd[2] = 32'h8000_0000;
    bnd[3] = 32'hFFFF_FFFF;
    stall = 1'b0; b_stall = 1'b0; acc = 1'b0; b_acc = 1'b0;
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data1 = '0; in_data2 = '0; in_func3 = '0; in_minmax = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data1 = '0; b_in_data2 = '0; b_in_func3 = '0; b_in_minmax = 1'b0; b_in_tag = '0;
    b_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_outs", {out_result, out_illegal, out_data, out_tag}, 0);
    chk("rst_in_ready", 64'(smp_in_ready), 0);
    chk("rst_outs_b", {b_out_valid, b_out_result, b_out_illegal, b_out_data, b_out_tag}, 0);
    rst = 1'b0;
    tick();
    chk("in_ready_after_rst", 64'(smp_in_ready), 1);

    // Directed vectors: one transaction at a time, latency checked exactly.
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b0, 5'h1A, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 5'h1A, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b000, 1'b0, 5'h01, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_0005, 3'b001, 1'b0, 5'h02, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 1'b0, 5'h03, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk(32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 1'b0, 5'h04, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(32'h0000_0001, 32'h0000_0002, 3'b010, 1'b0, 5'h05, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(32'h0000_0001, 32'h0000_0001, 3'b011, 1'b0, 5'h06, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(32'h1234_5600, 32'h1234_5700, 3'b100, 1'b0, 5'h07, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mk(32'h0000_0003, 32'h0000_0003, 3'b101, 1'b0, 5'h08, 1'b1, 1'b0, 32'h0));
`ifdef PIPELINED_COMPARATOR_MINMAX_EN
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b100, 1'b1, 5'h10, 1'b0, 1'b0, 32'h8000_0000));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b111, 1'b1, 5'h11, 1'b0, 1'b0, 32'h8000_0000));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b110, 1'b1, 5'h12, 1'b0, 1'b0, 32'h0000_0005));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b101, 1'b1, 5'h13, 1'b0, 1'b0, 32'h0000_0005));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b000, 1'b1, 5'h14, 1'b0, 1'b1, 32'h0));
`else
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b100, 1'b1, 5'h10, 1'b0, 1'b1, 32'h0));
    vecs.push_back(mk(32'h8000_0000, 32'h0000_0005, 3'b111, 1'b1, 5'h11, 1'b0, 1'b1, 32'h0));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1;
      in_data1 = vecs[i].a; in_data2 = vecs[i].b; in_func3 = vecs[i].f;
      in_minmax = vecs[i].mm; in_tag = vecs[i].tag;
      tick();
      chk($sformatf("vec%0d_accept", i), 64'(acc), 1);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early", i), 64'(out_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("vec%0d_fields", i), {out_result, out_illegal, out_data, out_tag},
          {vecs[i].res, vecs[i].ill, vecs[i].dat, vecs[i].tag});
      tick();
    end
    drain();

    // Back-to-back: 8 accepts in cycles 0..7, outputs in cycles 2..9 in order.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      new_a(TW'(c));
      tick();
      chk("b2b_valid", 64'(out_valid), 64'((c + 1) >= 2 && (c + 1) <= 9));
      if (out_valid) chk("b2b_tag", 64'(out_tag), 64'(c + 1 - 2));
    end
    drain();

    // Output stall with a full pipeline, then release.
    tg = 5'd16;
    out_ready = 1'b0;
    in_valid = 1'b1;
    new_a(tg);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_in_ready", 64'(smp_in_ready), 64'(c < 2));
      if (acc) begin tg = tg + 1'b1; new_a(tg); end
    end
    chk("stall_out_valid", 64'(out_valid), 1);
    chk("stall_out_tag", 64'(out_tag), 16);
    out_ready = 1'b1;
    for (int c = 0; c < 6 && !acc; c++) tick();
    chk("stall_release_accept", 64'(acc), 1);
    drain();

    // Flush with two in flight, then a fresh transaction.
    in_valid = 1'b1; new_a(5'd20); tick();
    new_a(5'd21); tick();
    out_ready = 1'b0; flush = 1'b1; new_a(5'd22); tick();
    chk("flush_in_ready", 64'(smp_in_ready), 0);
    flush = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", 64'(out_valid), 0);
    new_a(5'd23); tick();
    chk("flush_next_accept", 64'(acc), 1);
    in_valid = 1'b0;
    chk("flush_next_early", 64'(out_valid), 0);
    tick();
    chk("flush_next_valid", 64'(out_valid), 1);
    chk("flush_next_tag", 64'(out_tag), 23);
    drain();

    // Random traffic on both instances with random back-pressure,
    // occasional flush and one reset in the middle.
    tg = '0;
    tg_b = '0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        new_a(tg); tg = tg + 1'b1;
      end
      if (!b_in_valid || b_acc) begin
        b_in_valid = ($urandom_range(0, 3) != 0);
        new_b(tg_b); tg_b = tg_b + 1'b1;
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      rst = (c == 300);
      tick();
      if (c == 300) begin
        chk("rst_mid_a", {out_valid, out_result, out_illegal, out_data, out_tag}, 0);
        chk("rst_mid_b", {b_out_valid, b_out_result, b_out_illegal, b_out_data, b_out_tag}, 0);
        chk("rst_mid_in_ready", 64'(smp_in_ready), 0);
        rst = 1'b0;
        flush = 1'b0;
        tick();
        chk("rst_mid_in_ready_after", 64'(smp_in_ready), 1);
        chk("rst_mid_in_ready_after_b", 64'(smp_b_in_ready), 1);
      end
    end
    flush = 1'b0;
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
